// File: rtl/reel_spin_sequencer.sv
// Four-reel spin controller: free roll, timed spin, staggered per-reel lock onto RNG targets,
// timed result hold. All timing is clock-enable based inside the single clk domain.
module reel_spin_sequencer #(
    parameter int unsigned ROLL_DIV   = 35,
    parameter int unsigned SPIN_TICKS = 1400,
    parameter int unsigned LOCK_GAP   = 350,
    parameter int unsigned SHOW_TICKS = 3500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spin,
    input  logic [15:0] target_digits,
    output logic [15:0] reel_digits,
    output logic [3:0]  reel_locked,
    output logic        busy,
    output logic [1:0]  phase,
    output logic        done
);

    localparam int unsigned ARM_SPAN  = 3 * LOCK_GAP + 1;
    localparam int unsigned T_MAX_A   = (SPIN_TICKS > ARM_SPAN) ? SPIN_TICKS : ARM_SPAN;
    localparam int unsigned T_MAX     = (T_MAX_A > SHOW_TICKS) ? T_MAX_A : SHOW_TICKS;
    localparam int unsigned TW        = (T_MAX < 2) ? 1 : $clog2(T_MAX);
    localparam int unsigned PW        = (ROLL_DIV < 2) ? 1 : $clog2(ROLL_DIV);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSpin = 2'd1,
        StLock = 2'd2,
        StShow = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          spin_meta_q, spin_sync_q, spin_prev_q;
    logic [15:0]   digits_q, digits_d;
    logic [15:0]   tgt_q, tgt_d;
    logic [3:0]    locked_q, locked_d;
    logic          done_q, done_d;

    logic          roll_tick;
    logic          spin_edge;
    logic          spin_end;
    logic          show_end;
    logic [31:0]   timer_ext;
    logic [3:0]    match;

    assign roll_tick = (presc_q == PW'(ROLL_DIV - 1));
    assign spin_edge = spin_sync_q & ~spin_prev_q;
    assign spin_end  = (state_q == StSpin) && (timer_q == TW'(SPIN_TICKS - 1));
    assign show_end  = (state_q == StShow) && (timer_q == TW'(SHOW_TICKS - 1));
    assign timer_ext = 32'(timer_q);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (spin_edge)          state_d = StSpin;
            StSpin: if (spin_end)           state_d = StLock;
            StLock: if (locked_q == 4'hF)   state_d = StShow;
            StShow: if (show_end)           state_d = StIdle;
            default:                        state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        phase       = state_q;
        busy        = (state_q != StIdle);
        done        = done_q;
        reel_digits = digits_q;
        reel_locked = locked_q;
    end

    // Datapath next-state: reels, lock flags, timer, prescaler
    always_comb begin
        digits_d = digits_q;
        match    = 4'b0;
        for (int k = 0; k < 4; k++) begin
            logic [3:0] nib;
            logic       armed;
            logic       step;
            nib      = digits_q[4*k +: 4];
            armed    = (state_q == StLock) && (timer_ext >= 32'(k) * LOCK_GAP);
            match[k] = armed && !locked_q[k] && (nib == tgt_q[4*k +: 4]);
            // A reel caught on its target this cycle must not step away from it
            step     = roll_tick && (state_q != StShow) && !locked_q[k] && !match[k];
            if (step) begin
                digits_d[4*k +: 4] = (nib == 4'd0) ? 4'd9 : 4'(nib - 4'd1);
            end
        end

        locked_d = show_end ? 4'b0 : (locked_q | match);

        tgt_d = tgt_q;
        if (spin_end) begin
            for (int k = 0; k < 4; k++) begin
                tgt_d[4*k +: 4] = (target_digits[4*k +: 4] > 4'd9) ? 4'd9
                                                                     : target_digits[4*k +: 4];
            end
        end

        if (state_d != state_q || state_q == StIdle) begin
            timer_d = '0;
        end else if (timer_q != {TW{1'b1}}) begin
            timer_d = timer_q + TW'(1);
        end else begin
            timer_d = timer_q;
        end

        presc_d = roll_tick ? '0 : presc_q + PW'(1);
        done_d  = show_end;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q     <= '0;
            presc_q     <= '0;
            spin_meta_q <= 1'b0;
            spin_sync_q <= 1'b0;
            spin_prev_q <= 1'b0;
            digits_q    <= 16'h9999;
            tgt_q       <= 16'h0000;
            locked_q    <= 4'b0;
            done_q      <= 1'b0;
        end else begin
            timer_q     <= timer_d;
            presc_q     <= presc_d;
            spin_meta_q <= spin;
            spin_sync_q <= spin_meta_q;
            spin_prev_q <= spin_sync_q;
            digits_q    <= digits_d;
            tgt_q       <= tgt_d;
            locked_q    <= locked_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_reel_spin_sequencer.sv
// Bench for reel_spin_sequencer: a cycle reference model built from the phase rules, table-driven
// full runs, hand sequences for reset/immediate-match corners, and random spin/target stimulus.
module tb_reel_spin_sequencer;

    localparam int ROLL_DIV   = 2;
    localparam int SPIN_TICKS = 20;
    localparam int LOCK_GAP   = 10;
    localparam int SHOW_TICKS = 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spin = 1'b0;
    logic [15:0] target_digits = 16'h0000;
    logic [15:0] reel_digits;
    logic [3:0]  reel_locked;
    logic        busy;
    logic [1:0]  phase;
    logic        done;

    reel_spin_sequencer #(
        .ROLL_DIV   (ROLL_DIV),
        .SPIN_TICKS (SPIN_TICKS),
        .LOCK_GAP   (LOCK_GAP),
        .SHOW_TICKS (SHOW_TICKS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .spin          (spin),
        .target_digits (target_digits),
        .reel_digits   (reel_digits),
        .reel_locked   (reel_locked),
        .busy          (busy),
        .phase         (phase),
        .done          (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase number, elapsed cycles in phase, digit per reel, pin history
    int m_phase, m_timer, m_presc, m_done;
    int m_dig[4], m_tgt[4];
    bit m_lock[4];
    bit m_h1, m_h2, m_h3;
    int n_phase, n_timer, n_presc, n_done;
    int n_dig[4], n_tgt[4];
    bit n_lock[4];
    bit n_h1, n_h2, n_h3;

    task automatic model_reset();
        m_phase = 0; m_timer = 0; m_presc = 0; m_done = 0;
        m_h1 = 0; m_h2 = 0; m_h3 = 0;
        for (int k = 0; k < 4; k++) begin
            m_dig[k] = 9; m_tgt[k] = 0; m_lock[k] = 0;
        end
    endtask

    task automatic model_eval();
        bit rise, roll, all_locked, armed, match;
        rise = m_h2 && !m_h3;
        roll = (m_presc == ROLL_DIV - 1);
        all_locked = m_lock[0] && m_lock[1] && m_lock[2] && m_lock[3];
        n_h1 = spin; n_h2 = m_h1; n_h3 = m_h2;
        n_presc = roll ? 0 : m_presc + 1;
        for (int k = 0; k < 4; k++) begin
            armed = (m_phase == 2) && (m_timer >= k * LOCK_GAP);
            match = armed && !m_lock[k] && (m_dig[k] == m_tgt[k]);
            n_lock[k] = m_lock[k] || match;
            n_dig[k] = (roll && m_phase != 3 && !m_lock[k] && !match) ? (m_dig[k] + 9) % 10
                                                                         : m_dig[k];
            n_tgt[k] = m_tgt[k];
        end
        n_phase = m_phase; n_timer = m_timer + 1; n_done = 0;
        case (m_phase)
            0: begin
                n_timer = 0;
                if (rise) n_phase = 1;
            end
            1: if (m_timer == SPIN_TICKS - 1) begin
                n_phase = 2; n_timer = 0;
                for (int k = 0; k < 4; k++) begin
                    n_tgt[k] = int'(target_digits[4*k +: 4]);
                    if (n_tgt[k] > 9) n_tgt[k] = 9;
                end
            end
            2: if (all_locked) begin
                n_phase = 3; n_timer = 0;
            end
            default: if (m_timer == SHOW_TICKS - 1) begin
                n_phase = 0; n_timer = 0; n_done = 1;
                for (int k = 0; k < 4; k++) n_lock[k] = 0;
            end
        endcase
    endtask

    task automatic model_commit();
        if (!rst_n) begin
            model_reset();
        end else begin
            m_phase = n_phase; m_timer = n_timer; m_presc = n_presc; m_done = n_done;
            m_h1 = n_h1; m_h2 = n_h2; m_h3 = n_h3;
            for (int k = 0; k < 4; k++) begin
                m_dig[k] = n_dig[k]; m_tgt[k] = n_tgt[k]; m_lock[k] = n_lock[k];
            end
        end
    endtask

    function automatic logic [23:0] model_vec();
        logic [15:0] d;
        logic [3:0]  l;
        for (int k = 0; k < 4; k++) begin
            d[4*k +: 4] = 4'(m_dig[k]);
            l[k] = m_lock[k];
        end
        return {d, l, 1'(m_phase != 0), 2'(m_phase), 1'(m_done)};
    endfunction

    // Called at a negedge with inputs set; returns at the following negedge
    task automatic tick();
        model_eval();
        @(posedge clk);
        #1;
        model_commit();
        check("model", 32'({reel_digits, reel_locked, busy, phase, done}), 32'(model_vec()));
        @(negedge clk);
    endtask

    task automatic async_reset_check();
        rst_n = 1'b0;
        #1;
        check("async_rst_digits", 32'(reel_digits), 32'h9999);
        check("async_rst_locked", 32'(reel_locked), 32'h0);
        check("async_rst_phase", 32'({busy, phase, done}), 32'h0);
        model_reset();
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    int r_spin_len, r_show_len, r_hold_bad;
    int r_lt[4];
    logic [15:0] r_final;

    task automatic run_seq(input logic [15:0] tgt, input bit noisy, input bit chg);
        int guard;
        int off;
        r_spin_len = 0; r_show_len = 0; r_hold_bad = 0;
        for (int k = 0; k < 4; k++) r_lt[k] = -1;
        target_digits = tgt;
        spin = 1'b0;
        repeat (4) tick();
        spin = 1'b1;
        guard = 0;
        while (phase != 2'd1 && guard < 10) begin tick(); guard++; end
        check("spin_start", 32'(phase), 32'd1);
        while (phase == 2'd1 && guard < 200) begin
            r_spin_len++;
            if (noisy) spin = 1'($urandom_range(0, 1));
            tick(); guard++;
        end
        off = 0;
        while (phase == 2'd2 && guard < 400) begin
            for (int k = 0; k < 4; k++) if (reel_locked[k] && r_lt[k] < 0) r_lt[k] = off;
            if (chg && off == 5) target_digits = ~tgt;
            if (noisy) spin = 1'($urandom_range(0, 1));
            tick(); guard++; off++;
        end
        r_final = reel_digits;
        off = 0;
        while (phase == 2'd3 && guard < 600) begin
            if (reel_digits != r_final) r_hold_bad++;
            spin = (noisy && off < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
            r_show_len++;
            tick(); guard++; off++;
        end
        check("idle_after_show", 32'(phase), 32'd0);
        check("done_pulse", 32'(done), 32'd1);
        tick();
        check("done_width", 32'(done), 32'd0);
    endtask

    typedef struct {
        logic [15:0] tgt;
        bit          noisy;
        bit          chg;
        logic [15:0] expect_final;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int changes, bad_step, bad_eq, double_step, wrap_seen, guard;
        logic [15:0] prev;
        logic [3:0]  d0;

        vecs[0] = '{16'h1570, 1'b0, 1'b0, 16'h1570};
        vecs[1] = '{16'h1570, 1'b1, 1'b1, 16'h1570};
        vecs[2] = '{16'hFA3C, 1'b0, 1'b0, 16'h9939};
        vecs[3] = '{16'h0000, 1'b0, 1'b0, 16'h0000};
        vecs[4] = '{16'h9999, 1'b1, 1'b0, 16'h9999};
        vecs[5] = '{16'h5AB2, 1'b1, 1'b1, 16'h5992};

        model_reset();
        repeat (2) @(negedge clk);
        check("reset_state", 32'({reel_digits, reel_locked, busy, phase, done}),
              32'({16'h9999, 4'h0, 1'b0, 2'd0, 1'b0}));
        rst_n = 1'b1;
        tick();

        // Free roll in IDLE: one step per 2 clk, 9..0 wrap, all reels identical
        changes = 0; bad_step = 0; bad_eq = 0; double_step = 0; wrap_seen = 0;
        prev = reel_digits;
        for (int i = 0; i < 20; i++) begin
            bit changed_prev;
            changed_prev = (i > 0) && (prev != reel_digits);
            prev = reel_digits;
            tick();
            if (reel_digits != {4{reel_digits[3:0]}}) bad_eq++;
            if (reel_digits != prev) begin
                changes++;
                if (changed_prev) double_step++;
                if (reel_digits[3:0] != ((prev[3:0] == 4'd0) ? 4'd9 : prev[3:0] - 4'd1)) bad_step++;
                if (prev[3:0] == 4'd0 && reel_digits[3:0] == 4'd9) wrap_seen = 1;
            end
        end
        check("roll_changes", 32'(changes), 32'd10);
        check("roll_step_rule", 32'(bad_step), 32'd0);
        check("roll_equal", 32'(bad_eq), 32'd0);
        check("roll_rate", 32'(double_step), 32'd0);
        check("roll_wrap", 32'(wrap_seen), 32'd1);

        foreach (vecs[i]) begin
            run_seq(vecs[i].tgt, vecs[i].noisy, vecs[i].chg);
            check("spin_len", 32'(r_spin_len), 32'(SPIN_TICKS));
            check("show_len", 32'(r_show_len), 32'(SHOW_TICKS));
            check("final_digits", 32'(r_final), 32'(vecs[i].expect_final));
            check("show_hold", 32'(r_hold_bad), 32'd0);
            for (int k = 0; k < 4; k++) begin
                check("lock_seen", 32'(r_lt[k] >= 0), 32'd1);
                check("lock_not_early", 32'(r_lt[k] >= LOCK_GAP * k + 1), 32'd1);
                if (k > 0) check("lock_order", 32'(r_lt[k] >= r_lt[k-1]), 32'd1);
            end
        end

        // Asynchronous reset in the middle of LOCK
        target_digits = 16'h4826;
        spin = 1'b0;
        repeat (4) tick();
        spin = 1'b1;
        guard = 0;
        while (phase != 2'd2 && guard < 60) begin tick(); guard++; end
        check("reach_lock", 32'(phase), 32'd2);
        repeat (3) tick();
        async_reset_check();
        spin = 1'b0;
        repeat (4) tick();

        // Immediate match: reel0 target equals its digit at LOCK entry
        target_digits = 16'h8640;
        spin = 1'b1;
        guard = 0;
        while (!(m_phase == 1 && m_timer == SPIN_TICKS - 1) && guard < 60) begin
            tick(); guard++;
        end
        check("reach_spin_end", 32'(phase), 32'd1);
        d0 = 4'((m_presc == ROLL_DIV - 1) ? (m_dig[0] + 9) % 10 : m_dig[0]);
        target_digits[3:0] = d0;
        tick();
        check("imm_entry_phase", 32'(phase), 32'd2);
        check("imm_entry_unlocked", 32'(reel_locked[0]), 32'd0);
        check("imm_entry_digit", 32'(reel_digits[3:0]), 32'(d0));
        tick();
        check("imm_locked", 32'(reel_locked[0]), 32'd1);
        bad_step = 0;
        guard = 0;
        while (phase != 2'd0 && guard < 200) begin
            if (reel_digits[3:0] != d0) bad_step++;
            tick(); guard++;
        end
        check("imm_reel0_held", 32'(bad_step), 32'd0);
        check("imm_back_idle", 32'(phase), 32'd0);

        // Random spin activity and targets against the model
        for (int it = 0; it < 8; it++) begin
            target_digits = 16'($urandom);
            for (int c = 0; c < 220; c++) begin
                if ($urandom_range(0, 7) == 0) spin = ~spin;
                if ($urandom_range(0, 40) == 0) target_digits = 16'($urandom);
                if (it == 5 && c == 90) async_reset_check();
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
